// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch stage for the MIPS core.
// Issues one word read per fetch on the Avalon-style instruction port, rides out
// waitrequest stalls, and hands the fetched word to decode over a valid/ready
// handshake. Misaligned PCs produce a one-cycle fetch_err with no bus access, and
// a flush drops any in-flight or held fetch without breaking the bus protocol.
module mips_cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        drop_r, drop_s;
  logic [31:0] addr_r, addr_s;
  logic        read_r, read_s;
  logic [3:0]  be_r, be_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        valid_r, valid_s;
  logic        err_r, err_s;
  logic        busy_r;
  logic        try_fetch_s;

  // Word alignment test on the two low address bits.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decode; flush outranks every other request.
  always_comb begin
    state_s     = state_r;
    drop_s      = drop_r;
    addr_s      = addr_r;
    read_s      = read_r;
    be_s        = be_r;
    instr_s     = instr_r;
    instr_pc_s  = instr_pc_r;
    valid_s     = valid_r;
    err_s       = 1'b0;
    try_fetch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_en && !flush) begin
          try_fetch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // A flush here cannot abort the bus cycle; remember to drop its data.
        if (flush) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
        if (!avm_waitrequest) begin
          read_s  = 1'b0;
          be_s    = 4'h0;
          state_s = RESP;
        end else begin
          state_s = REQ;
        end
      end
      RESP: begin
        if (flush || drop_r) begin
          drop_s  = 1'b0;
          state_s = IDLE;
        end else begin
          instr_s    = avm_readdata;
          instr_pc_s = addr_r;
          valid_s    = 1'b1;
          drop_s     = 1'b0;
          state_s    = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          valid_s = 1'b0;
          instr_s = NOP_WORD;
          state_s = IDLE;
        end else if (instr_ready) begin
          // Handshake done; a simultaneous fetch_en launches with no bubble.
          valid_s     = 1'b0;
          instr_s     = NOP_WORD;
          state_s     = IDLE;
          try_fetch_s = fetch_en;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        read_s  = 1'b0;
        be_s    = 4'h0;
        drop_s  = 1'b0;
        valid_s = 1'b0;
      end
    endcase
    if (try_fetch_s) begin
      if (is_aligned(pc[1:0])) begin
        addr_s  = pc;
        read_s  = 1'b1;
        be_s    = 4'hF;
        drop_s  = 1'b0;
        state_s = REQ;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // Datapath and output registers; busy is registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_r     <= 1'b0;
      addr_r     <= 32'h00000000;
      read_r     <= 1'b0;
      be_r       <= 4'h0;
      instr_r    <= NOP_WORD;
      instr_pc_r <= RESET_VECTOR;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      drop_r     <= drop_s;
      addr_r     <= addr_s;
      read_r     <= read_s;
      be_r       <= be_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      valid_r    <= valid_s;
      err_r      <= err_s;
      busy_r     <= (state_s == REQ) || (state_s == RESP);
    end
  end

  assign avm_address    = addr_r;
  assign avm_read       = read_r;
  assign avm_byteenable = be_r;
  assign instr          = instr_r;
  assign instr_pc       = instr_pc_r;
  assign instr_valid    = valid_r;
  assign fetch_err      = err_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Table-driven bench for mips_cpu_ifetch: one row per clock cycle holding the
// inputs driven in that cycle and the registered outputs expected in it.
module tb_mips_cpu_ifetch;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  mips_cpu_ifetch dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_err(fetch_err), .busy(busy)
  );

  typedef struct {
    logic        en, fl, wr, rdy;
    logic [31:0] pc, rdata;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_ipc;
    logic        e_err, e_busy;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic en, input logic fl, input logic wr, input logic rdy,
    input logic [31:0] p, input logic [31:0] rd_data,
    input logic e_rd, input logic [31:0] e_addr, input logic e_valid,
    input logic [31:0] e_instr, input logic [31:0] e_ipc,
    input logic e_err, input logic e_busy);
    vec_t v;
    v.en = en; v.fl = fl; v.wr = wr; v.rdy = rdy; v.pc = p; v.rdata = rd_data;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack_out();
    return {avm_read, avm_byteenable, instr_valid, instr, instr_pc, fetch_err, busy};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    logic [71:0] exp_v;
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1; pc = 32'h0; fetch_en = 1'b0; flush = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = 32'h0; instr_ready = 1'b0;

    //        en    fl    wr    rdy   pc             rdata          rd    addr           vld   instr          ipc            err   busy
    // basic zero-wait fetch
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, RV,            32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         RV,            1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, RV,            32'h0,         1'b1, RV,            1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, RV,            32'h24020005,  1'b0, 32'h0,         1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, RV,            32'h0,         1'b0, 32'h0,         1'b1, 32'h24020005,  RV,            1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, RV,            32'h0,         1'b0, 32'h0,         1'b1, 32'h24020005,  RV,            1'b0, 1'b0);
    // fetch with three waitrequest cycles
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, RV,            32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         RV,            1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h40,        32'h0,         1'b1, RV,            1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h40,        32'h0,         1'b1, RV,            1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h40,        32'h0,         1'b1, RV,            1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40,        32'h0,         1'b1, RV,            1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40,        32'h8C880010,  1'b0, 32'h0,         1'b0, 32'h0,         RV,            1'b0, 1'b1);
    // hold with ready low for five cycles, then handshake plus next fetch
    for (int k = 11; k <= 15; k++) begin
      vecs[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40,       32'h0,         1'b0, 32'h0,         1'b1, 32'h8C880010,  RV,            1'b0, 1'b0);
    end
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC00004,  32'h0,         1'b0, 32'h0,         1'b1, 32'h8C880010,  RV,            1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00004,  32'h0,         1'b1, 32'hBFC00004,  1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00004,  32'h3C1DA000,  1'b0, 32'h0,         1'b0, 32'h0,         RV,            1'b0, 1'b1);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00004,  32'h0,         1'b0, 32'h0,         1'b1, 32'h3C1DA000,  32'hBFC00004,  1'b0, 1'b0);
    // misaligned pc
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC00002,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00002,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b1, 1'b0);
    // flush during a stalled request
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC00010,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b0);
    vecs[23] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'hBFC00010,  32'h0,         1'b1, 32'hBFC00010,  1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    vecs[24] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'hBFC00010,  32'h0,         1'b1, 32'hBFC00010,  1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00010,  32'h0,         1'b1, 32'hBFC00010,  1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00010,  32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    // fetch_en together with flush is ignored
    vecs[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC00020,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b0);
    vecs[28] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC00020,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b0);
    // flush while holding a valid instruction
    vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00020,  32'h0,         1'b1, 32'hBFC00020,  1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    vecs[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00020,  32'h11111111,  1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00004,  1'b0, 1'b1);
    vecs[31] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hBFC00020,  32'h0,         1'b0, 32'h0,         1'b1, 32'h11111111,  32'hBFC00020,  1'b0, 1'b0);
    // flush while the response is on the bus
    vecs[32] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC00024,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00020,  1'b0, 1'b0);
    vecs[33] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00024,  32'h0,         1'b1, 32'hBFC00024,  1'b0, 32'h0,         32'hBFC00020,  1'b0, 1'b1);
    vecs[34] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hBFC00024,  32'h22222222,  1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00020,  1'b0, 1'b1);
    vecs[35] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00024,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'hBFC00020,  1'b0, 1'b0);

    // reset state, checked while reset is still asserted
    #2;
    check("reset_state", {40'h0, avm_address}, {40'h0, 32'h0});
    check("reset_outputs", pack_out(), {1'b0, 4'h0, 1'b0, 32'h0, RV, 1'b0, 1'b0});

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      fetch_en = vecs[i].en;
      flush = vecs[i].fl;
      avm_waitrequest = vecs[i].wr;
      instr_ready = vecs[i].rdy;
      pc = vecs[i].pc;
      avm_readdata = vecs[i].rdata;
      exp_v = {vecs[i].e_rd, (vecs[i].e_rd ? 4'hF : 4'h0), vecs[i].e_valid,
               vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_err, vecs[i].e_busy};
      check($sformatf("row%0d", i), pack_out(), exp_v);
      if (vecs[i].e_rd) begin
        check($sformatf("row%0d_addr", i), {40'h0, avm_address}, {40'h0, vecs[i].e_addr});
      end
      @(negedge clk);
    end

    // reset asserted mid-request drops the read at once
    fetch_en = 1'b1; flush = 1'b0; pc = RV; avm_waitrequest = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    fetch_en = 1'b0;
    check("req_before_reset", pack_out(), {1'b1, 4'hF, 1'b0, 32'h0, 32'hBFC00020, 1'b0, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", pack_out(), {1'b0, 4'h0, 1'b0, 32'h0, RV, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h55555555;
    @(negedge clk);
    check("post_reset_idle1", pack_out(), {1'b0, 4'h0, 1'b0, 32'h0, RV, 1'b0, 1'b0});
    @(negedge clk);
    check("post_reset_idle2", pack_out(), {1'b0, 4'h0, 1'b0, 32'h0, RV, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
